// File: rtl/simd_pkg.sv
// Shared types and thread-id helpers for the SIMD wave scheduler
// and the ALU/LSU address generators.
package simd_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_READY   = 2'd1,
    S_ISSUING = 2'd2,
    S_WAITING = 2'd3
  } slot_state_t;

  // Values for the default 32-thread, 16-lane, 4-slot build.
  localparam int CYCLES_PER_WAVE = 32 / 16;
  localparam int SLOT_W = $clog2(4);

  function automatic logic [31:0] tid_local(
    input logic [31:0] wave_id,
    input logic [31:0] cycle,
    input logic [31:0] lane,
    input int          wave_size,
    input int          lane_width
  );
    return wave_id * 32'(wave_size)
         + cycle * 32'(lane_width) + lane;
  endfunction

  function automatic logic tid_active(
    input logic [31:0] lid,
    input logic [31:0] block_id,
    input logic [31:0] block_dim,
    input logic [31:0] num_threads
  );
    logic [31:0] g;
    g = block_id * block_dim + lid;
    return (lid < block_dim) && (g < num_threads);
  endfunction

endpackage

// File: rtl/simd_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr,
// wrapping modulo N.
module simd_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  int j;

  // Walk from farthest to nearest so the nearest wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = W'(j);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simd_wave_scheduler.sv
// Multi-wavefront scheduler: slot table, round-robin
// selection and lane-width beat sequencing.
module simd_wave_scheduler
  import simd_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
  parameter int WAVE_SIZE  = 32,
  parameter int LANE_WIDTH = 16,
  parameter int NUM_SLOTS  = 4,
  localparam int PA = PROGRAM_MEM_ADDR_WIDTH,
  localparam int C  = WAVE_SIZE / LANE_WIDTH,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           num_threads,
  input  logic [31:0]           block_dim,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic [31:0]           dispatch_block_id,
  input  logic [31:0]           dispatch_wave_id,
  input  logic [PA-1:0]         dispatch_pc,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [SW-1:0]         issue_slot,
  output logic [PA-1:0]         issue_pc,
  output logic [CW-1:0]         issue_cycle,
  output logic [31:0]           issue_thread_base,
  output logic [LANE_WIDTH-1:0] issue_lane_mask,
  input  logic                  commit_valid,
  input  logic [SW-1:0]         commit_slot,
  input  logic [PA-1:0]         commit_next_pc,
  input  logic                  commit_done,
  output logic                  retire_valid,
  output logic [SW-1:0]         retire_slot,
  output logic                  idle,
  output logic                  protocol_err
);

  slot_state_t state_q [NUM_SLOTS];
  slot_state_t state_d [NUM_SLOTS];
  logic [31:0] blk_q [NUM_SLOTS];
  logic [31:0] blk_d [NUM_SLOTS];
  logic [31:0] wav_q [NUM_SLOTS];
  logic [31:0] wav_d [NUM_SLOTS];
  logic [PA-1:0] pc_q [NUM_SLOTS];
  logic [PA-1:0] pc_d [NUM_SLOTS];

  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          ret_v_q, ret_v_d;
  logic [SW-1:0] ret_s_q, ret_s_d;
  logic          err_q, err_d;

  logic [NUM_SLOTS-1:0] empty_v, ready_v, grant;
  logic [SW-1:0] gidx, didx;
  logic          gval, any_empty;
  logic [31:0]   lid;

  always_comb begin
    empty_v = '0;
    ready_v = '0;
    didx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      empty_v[i] = (state_q[i] == S_EMPTY);
      ready_v[i] = (state_q[i] == S_READY);
      if (empty_v[i]) didx = SW'(i);
    end
    any_empty = |empty_v;
  end

  simd_rr_arbiter #(.N(NUM_SLOTS), .W(SW)) u_arb (
    .req   (ready_v),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (gidx),
    .valid (gval)
  );

  assign dispatch_ready = rst && enable && any_empty;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    wav_d   = wav_q;
    pc_d    = pc_q;
    rr_d    = rr_q;
    cur_d   = cur_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    ret_v_d = 1'b0;
    ret_s_d = ret_s_q;
    err_d   = err_q;
    if (dispatch_valid && dispatch_ready) begin
      state_d[didx] = S_READY;
      blk_d[didx]   = dispatch_block_id;
      wav_d[didx]   = dispatch_wave_id;
      pc_d[didx]    = dispatch_pc;
    end
    if (enable && !busy_q && gval) begin
      state_d[gidx] = S_ISSUING;
      busy_d = 1'b1;
      cur_d  = gidx;
      cyc_d  = '0;
      rr_d   = (gidx == SW'(NUM_SLOTS - 1)) ? '0 : gidx + 1'b1;
    end
    if (busy_q && issue_ready) begin
      if (cyc_q == CW'(C - 1)) begin
        state_d[cur_q] = S_WAITING;
        busy_d = 1'b0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
    // Commits to any slot not awaiting completion are dropped.
    if (commit_valid) begin
      if (state_q[commit_slot] == S_WAITING) begin
        if (commit_done) begin
          state_d[commit_slot] = S_EMPTY;
          ret_v_d = 1'b1;
          ret_s_d = commit_slot;
        end else begin
          state_d[commit_slot] = S_READY;
          pc_d[commit_slot]    = commit_next_pc;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    issue_valid       = busy_q;
    issue_slot        = busy_q ? cur_q : '0;
    issue_pc          = busy_q ? pc_q[cur_q] : '0;
    issue_cycle       = busy_q ? cyc_q : '0;
    issue_thread_base = '0;
    issue_lane_mask   = '0;
    lid = tid_local(wav_q[cur_q], 32'(cyc_q), 32'd0,
                    WAVE_SIZE, LANE_WIDTH);
    if (busy_q) begin
      issue_thread_base = blk_q[cur_q] * block_dim + lid;
      for (int l = 0; l < LANE_WIDTH; l++) begin
        issue_lane_mask[l] = tid_active(lid + 32'(l),
          blk_q[cur_q], block_dim, num_threads);
      end
    end
  end

  always_comb begin
    idle = !busy_q && (&empty_v);
  end

  assign retire_valid = ret_v_q;
  assign retire_slot  = ret_s_q;
  assign protocol_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_EMPTY;
        blk_q[i]   <= '0;
        wav_q[i]   <= '0;
        pc_q[i]    <= '0;
      end
      rr_q    <= '0;
      cur_q   <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      ret_v_q <= 1'b0;
      ret_s_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      wav_q   <= wav_d;
      pc_q    <= pc_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      ret_v_q <= ret_v_d;
      ret_s_q <= ret_s_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/simd_wave_scheduler.md
# simd_wave_scheduler

Multi-wavefront successor to the single-wave SIMD unit. Holds up to NUM_SLOTS resident wavefronts, each with its own PC and state. Wavefronts are selected round-robin, and each instruction is split into WAVE_SIZE/LANE_WIDTH lane-width beats. Each beat carries the global thread base and an active-lane mask for the vector ALU/LSU. The block sits between the wave dispatcher (upstream) and the lane datapath (downstream).

## Interface
- PROGRAM_MEM_ADDR_WIDTH, 32, PC width
- WAVE_SIZE, 32, threads per wavefront; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 16, SIMD lanes per beat
- NUM_SLOTS, 4, resident wave slots; must be ≥2
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  permits dispatch and new instruction starts
- num_threads  in  32  total kernel threads
- block_dim  in  32  threads per block
- dispatch_valid / dispatch_ready  in / out  1  wave-assignment handshake
- dispatch_block_id, dispatch_wave_id  in  32  ids of the incoming wave (unsigned)
- dispatch_pc  in  PROGRAM_MEM_ADDR_WIDTH  start PC
- issue_valid / issue_ready  out / in  1  beat handshake to the lanes
- issue_slot  out  clog2(NUM_SLOTS)  slot of the beat
- issue_pc  out  PROGRAM_MEM_ADDR_WIDTH  PC of the instruction
- issue_cycle  out  clog2(WAVE_SIZE/LANE_WIDTH) (min 1)  warp-cycle index
- issue_thread_base  out  32  global id of lane 0
- issue_lane_mask  out  LANE_WIDTH  active lanes
- commit_valid  in  1  instruction completion
- commit_slot  in  clog2(NUM_SLOTS)  slot that completed
- commit_next_pc  in  PROGRAM_MEM_ADDR_WIDTH  next PC for that slot
- commit_done  in  1  wave has executed its exit instruction
- retire_valid  out  1  one-cycle pulse when a slot frees
- retire_slot  out  clog2(NUM_SLOTS)  slot freed
- idle  out  1  all slots EMPTY and no beat pending
- protocol_err  out  1  sticky illegal-commit flag

## Operation
- Per-slot state is EMPTY, READY, ISSUING or WAITING. Each slot also holds block_id, wave_id and pc.
- Dispatch:
  - dispatch_ready = enable && any slot EMPTY, computed from registered state.
  - On handshake, the lowest-indexed EMPTY slot becomes READY with pc = dispatch_pc.
- Selection:
  - With enable high and no instruction in flight, the round-robin arbiter picks the first READY slot starting at rr_ptr.
  - That slot becomes ISSUING. rr_ptr becomes the selected slot + 1, modulo NUM_SLOTS.
- Issue:
  - The ISSUING slot emits C = WAVE_SIZE/LANE_WIDTH beats, issue_cycle = 0..C-1. Beats of different slots never interleave.
  - The beat advances on issue_valid && issue_ready. Beat outputs hold while issue_ready is low.
  - After the last beat is accepted, the slot goes to WAITING.
- Thread id, mod 2^32 unsigned:
  - local = wave_id*WAVE_SIZE + cycle*LANE_WIDTH + lane.
  - g = block_id*block_dim + local.
  - issue_thread_base = g at lane 0.
  - Mask bit = (local < block_dim) && (g < num_threads).
  - An all-zero mask is still issued as a normal beat.
- Commit:
  - commit_valid on a WAITING slot with commit_done=0: the slot returns to READY with pc = commit_next_pc.
  - With commit_done=1: the slot goes to EMPTY, and retire_valid/retire_slot pulse the next cycle.
  - Commit to a non-WAITING slot is ignored and sets protocol_err, which clears only on reset.
- enable low: no new selection and dispatch_ready = 0. An in-flight instruction finishes all its beats, and commits are still accepted.

## Timing
- Reset values:
  - All slots EMPTY, rr_ptr = 0.
  - issue_valid, retire_valid, protocol_err, dispatch_ready = 0; every other output = 0.
  - idle = 1.
- Dispatch accepted at edge t:
  - dispatch_ready reflects the updated slot state from cycle t+1.
  - Earliest first beat (issue_valid high) is in cycle t+2.
- Between two instructions, issue_valid is low for exactly one cycle, the selection cycle.
- Commit at edge t: the slot is READY in cycle t+1, and its earliest beat is in cycle t+2.
- Same-cycle dispatch and commit on different slots are both honoured.
- A slot freed at edge t is not dispatchable until cycle t+1.
- Reset asserted mid-instruction clears everything immediately. A partial instruction is abandoned with no retire pulse.

## Structure
- Shared package simd_pkg:
  - slot_state_t enum.
  - Localparams CYCLES_PER_WAVE and SLOT_W.
  - Thread-id/mask function, shared with the ALU/LSU address generation.
- One sub-module, simd_rr_arbiter: NUM_SLOTS-wide request vector plus rr_ptr in, one-hot grant and index out.
- Per-slot PCs are a register array here; no per-slot PC instances.

## Test plan
- Reset, then one dispatch (block 1, wave 0, block_dim 64, num_threads 1000, pc 0x40) with issue_ready high:
  - Two beats in cycles t+2 and t+3, pc 0x40.
  - Thread bases 64 and 80, both masks 0xFFFF.
- Partial wave (block 0, wave 1, block_dim 40, num_threads 1000):
  - Beat 0: base 32, mask 0x00FF.
  - Beat 1: base 48, mask 0x0000, still issued.
- Four dispatches, commit each without done:
  - Issue order is slots 0,1,2,3,0.
  - A fifth dispatch attempt sees dispatch_ready = 0.
- issue_ready low for 3 cycles on beat 0: outputs held stable, issue_cycle stays 0, no other slot interleaves.
- commit_done on slot 2: retire_valid pulses with retire_slot = 2; the next dispatch lands in slot 2.
- Commit to an EMPTY slot: protocol_err goes high and stays high; slot states are unchanged.
